// File: rtl/soc_bus_mux.sv
// soc_bus_mux: data-bus interconnect between the core load/store port and N_SLV
// memory-mapped slaves.
//
// The upper address nibble selects the slave. A single request is outstanding at a
// time. The master sees a req/gnt handshake followed by exactly one registered
// response pulse (m_rvalid_o) per accepted request. Unmapped accesses are granted
// at once and answered with an error response, so the core never hangs.
//
// Optional feature (compile-time macro BUS_TIMEOUT_EN):
//   defined   - a counter runs while waiting for the slave. After TIMEOUT cycles
//               without a response the access completes with an error.
//   undefined - no counter is built and the mux waits for the slave indefinitely.
//
// Parameters:
//   N_SLV    number of slave ports (1..16)
//   ADDR_W   address width
//   DATA_W   data width (multiple of 8)
//   TIMEOUT  response timeout in cycles (>= 1, used only with BUS_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   m_req_i .. m_wdata_i  master request fields
//   m_gnt_o               request accepted this cycle (combinational)
//   m_rvalid_o            response pulse, one per accepted request (registered)
//   m_rdata_o, m_err_o    response data / error flag, held until the next response
//   s_req_o               one-hot request to the selected slave (combinational)
//   s_we_o .. s_wdata_o   broadcast copies of the master fields
//   s_gnt_i               per-slave grant
//   s_rvalid_i            per-slave response valid
//   s_rdata_i             packed slave read data, slave k at [k*DATA_W +: DATA_W]

module soc_bus_mux #(
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Master (core) side
  input  logic                    m_req_i,
  input  logic                    m_we_i,
  input  logic [DATA_W/8-1:0]     m_be_i,
  input  logic [ADDR_W-1:0]       m_addr_i,
  input  logic [DATA_W-1:0]       m_wdata_i,
  output logic                    m_gnt_o,
  output logic                    m_rvalid_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic                    m_err_o,
  // Slave side
  output logic [N_SLV-1:0]        s_req_o,
  output logic                    s_we_o,
  output logic [DATA_W/8-1:0]     s_be_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  input  logic [N_SLV-1:0]        s_gnt_i,
  input  logic [N_SLV-1:0]        s_rvalid_i,
  input  logic [N_SLV*DATA_W-1:0] s_rdata_i
);

  // Elaboration-time parameter sanity check.
  if (N_SLV < 1 || N_SLV > 16 || TIMEOUT < 1 || (DATA_W % 8) != 0 || ADDR_W < 4)
  begin : g_param_check
    $error("soc_bus_mux: illegal parameter value");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWaitRsp,
    StErrRsp
  } state_e;

  state_e              state_q;
  logic [3:0]          sel_q;     // slave index of the outstanding access
  logic                we_q;      // outstanding access is a write
  logic                rvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

`ifdef BUS_TIMEOUT_EN
  // Counts completed WAIT_RSP cycles; holds values 0..TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CntW-1:0]     cnt_q;
  logic                cnt_expired;
  assign cnt_expired = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  // ---------------------------------------------------------------------------
  // Address decode and per-slave selection
  // ---------------------------------------------------------------------------
  logic [3:0]        idx;
  logic              mapped;
  logic              req_act;
  logic              slv_gnt;
  logic              slv_rvalid;
  logic [DATA_W-1:0] slv_rdata;

  assign idx    = m_addr_i[ADDR_W-1 -: 4];
  assign mapped = (32'(idx) < N_SLV);

  // Gating with rst_n keeps every combinational output quiet while reset is held,
  // whatever the master drives.
  assign req_act = m_req_i & rst_n;

  // Loops rather than variable bit-selects keep index widths exact for any N_SLV.
  always_comb begin
    slv_gnt    = 1'b0;
    slv_rvalid = 1'b0;
    slv_rdata  = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (idx == 4'(k)) begin
        slv_gnt = s_gnt_i[k];
      end
      if (sel_q == 4'(k)) begin
        slv_rvalid = s_rvalid_i[k];
        slv_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational request path
  // ---------------------------------------------------------------------------
  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (req_act && state_q == StIdle) begin
      if (mapped) begin
        for (int unsigned k = 0; k < N_SLV; k++) begin
          if (idx == 4'(k)) begin
            s_req_o[k] = 1'b1;
          end
        end
        m_gnt_o = slv_gnt;
      end else begin
        // Nobody to ask: accept at once and answer with an error.
        m_gnt_o = 1'b1;
      end
    end
  end

  assign s_we_o    = req_act & m_we_i;
  assign s_be_o    = req_act ? m_be_i    : '0;
  assign s_addr_o  = req_act ? m_addr_i  : '0;
  assign s_wdata_o = req_act ? m_wdata_i : '0;

  // ---------------------------------------------------------------------------
  // FSM with registered response outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // m_rvalid_o is a one-cycle pulse; rdata/err hold until the next response.
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m_gnt_o) begin
            if (mapped) begin
              sel_q   <= idx;
              we_q    <= m_we_i;
              state_q <= StWaitRsp;
`ifdef BUS_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= StErrRsp;
            end
          end
        end
        StWaitRsp: begin
          // A response in the expiry cycle wins over the timeout.
          if (slv_rvalid) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= we_q ? '0 : slv_rdata;
            state_q  <= StIdle;
`ifdef BUS_TIMEOUT_EN
          end else if (cnt_expired) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            state_q  <= StIdle;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
`endif
          end
        end
        StErrRsp: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
          rdata_q  <= '0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_rvalid_o = rvalid_q;
  assign m_err_o    = err_q;
  assign m_rdata_o  = rdata_q;

endmodule

// File: tb/tb_soc_bus_mux.sv
module tb_soc_bus_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m_req_i = 1'b0;
  logic            m_we_i = 1'b0;
  logic [BW-1:0]   m_be_i = '0;
  logic [AW-1:0]   m_addr_i = '0;
  logic [DW-1:0]   m_wdata_i = '0;
  logic            m_gnt_o;
  logic            m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            m_err_o;
  logic [N-1:0]    s_req_o;
  logic            s_we_o;
  logic [BW-1:0]   s_be_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [N-1:0]    s_gnt_i = '0;
  logic [N-1:0]    s_rvalid_i = '0;
  logic [N*DW-1:0] s_rdata_i = '0;

  soc_bus_mux #(
    .N_SLV  (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req_i   (m_req_i),
    .m_we_i    (m_we_i),
    .m_be_i    (m_be_i),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_gnt_o   (m_gnt_o),
    .m_rvalid_o(m_rvalid_o),
    .m_rdata_o (m_rdata_o),
    .m_err_o   (m_err_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_gnt_i   (s_gnt_i),
    .s_rvalid_i(s_rvalid_i),
    .s_rdata_i (s_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    bit          rst;
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    int          rslv;     // slave whose read data is 'rdata'; others carry a marker
    logic [31:0] rdata;
    bit          e_gnt;
    logic [3:0]  e_sreq;
    bit          e_rv;
    bit          e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  // Reference model: at most one pending transaction record.
  bit          pend;
  int          tgt;        // -1 marks an unmapped (error) access
  bit          pwr;
  int          waited;
  bit          mv;
  bit          me;
  logic [31:0] md;

  function automatic vec_t row(bit rst, bit req, bit we, logic [3:0] be, logic [31:0] addr,
                               logic [31:0] wdata, logic [3:0] gnt, logic [3:0] rv, int rslv,
                               logic [31:0] rdata, bit e_gnt, logic [3:0] e_sreq, bit e_rv,
                               bit e_err, logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.gnt = gnt; v.rv = rv; v.rslv = rslv; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_sreq = e_sreq; v.e_rv = e_rv; v.e_err = e_err; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Cycle with no master request.
  function automatic vec_t idle(logic [3:0] rv, int rslv, logic [31:0] rdata, bit e_rv,
                                bit e_err, logic [31:0] e_rdata);
    return row(1, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0, rv, rslv, rdata, 0, 4'h0, e_rv, e_err,
               e_rdata);
  endfunction

  function automatic logic [31:0] slice_val(vec_t v, int k);
    return (k == v.rslv) ? v.rdata : (32'hBAD0_0000 | 32'(k));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; tgt = 0; pwr = 0; waited = 0; mv = 0; me = 0; md = '0;
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [3:0] idx;
    bit         mapped;
    bit         active;
    logic [3:0] x_sreq;
    bit         x_gnt;
    logic [68:0] x_bus;
    @(negedge clk);
    rst_n = v.rst; m_req_i = v.req; m_we_i = v.we; m_be_i = v.be; m_addr_i = v.addr;
    m_wdata_i = v.wdata; s_gnt_i = v.gnt; s_rvalid_i = v.rv;
    for (int k = 0; k < int'(N); k++) s_rdata_i[k*DW +: DW] = slice_val(v, k);
    if (!v.rst) model_reset();
    #1;
    idx    = v.addr[31:28];
    mapped = (idx < 4'(N));
    active = v.rst && v.req && !pend;
    x_sreq = (active && mapped) ? (4'b0001 << idx[1:0]) : 4'b0000;
    x_gnt  = active && (mapped ? v.gnt[idx[1:0]] : 1'b1);
    x_bus  = (v.rst && v.req) ? {v.we, v.be, v.addr, v.wdata} : '0;
    if (use_tbl) begin
      chk({tag, " gnt"},    128'(m_gnt_o),    128'(v.e_gnt));
      chk({tag, " s_req"},  128'(s_req_o),    128'(v.e_sreq));
      chk({tag, " rvalid"}, 128'(m_rvalid_o), 128'(v.e_rv));
      chk({tag, " err"},    128'(m_err_o),    128'(v.e_err));
      chk({tag, " rdata"},  128'(m_rdata_o),  128'(v.e_rdata));
    end else begin
      chk({tag, " gnt"},    128'(m_gnt_o),    128'(x_gnt));
      chk({tag, " s_req"},  128'(s_req_o),    128'(x_sreq));
      chk({tag, " rvalid"}, 128'(m_rvalid_o), 128'(mv));
      chk({tag, " err"},    128'(m_err_o),    128'(me));
      chk({tag, " rdata"},  128'(m_rdata_o),  128'(md));
    end
    chk({tag, " bcast"}, 128'({s_we_o, s_be_o, s_addr_o, s_wdata_o}), 128'(x_bus));
    @(posedge clk);
    if (v.rst) begin
      mv = 0;
      if (pend) begin
        if (tgt < 0) begin
          mv = 1; me = 1; md = '0; pend = 0;
        end else if (v.rv[tgt]) begin
          mv = 1; me = 0; md = pwr ? 32'h0 : slice_val(v, tgt); pend = 0;
        end else begin
          waited++;
`ifdef BUS_TIMEOUT_EN
          if (waited >= int'(TO)) begin
            mv = 1; me = 1; md = '0; pend = 0;
          end
`endif
        end
      end else if (x_gnt) begin
        pend = 1; tgt = mapped ? int'(idx) : -1; pwr = v.we; waited = 0;
      end
    end
  endtask

  initial begin
    vec_t v;
    model_reset();

    // Reset held with random inputs: every output must be 0.
    for (int c = 0; c < 6; c++) begin
      v = row(0, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom),
              4'($urandom), int'($urandom_range(0, 3)), $urandom, 0, 4'h0, 0, 0, 32'h0);
      step(v, 1, "reset");
    end

    // Read from slave 2, one-cycle slave response.
    tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h2000_0010, 0, 4'b0100, 0, 0, 0,
                      1, 4'b0100, 0, 0, 32'h0));
    tbl.push_back(idle(4'b0100, 2, 32'hDEAD_BEEF, 0, 0, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'hDEAD_BEEF));
    // Write to slave 0, grant delayed 3 cycles.
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(1, 1, 1, 4'b0011, 32'h0000_0040, 32'h1234_5678, 4'h0, 0, 0, 0,
                        0, 4'b0001, 0, 0, 32'hDEAD_BEEF));
    tbl.push_back(row(1, 1, 1, 4'b0011, 32'h0000_0040, 32'h1234_5678, 4'b0001, 0, 0, 0,
                      1, 4'b0001, 0, 0, 32'hDEAD_BEEF));
    tbl.push_back(idle(4'b0001, 0, 32'hFFFF_0000, 0, 0, 32'hDEAD_BEEF));
    tbl.push_back(idle(4'h0, 0, 0, 1, 0, 32'h0));
    // Unmapped access.
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h9000_0000, 0, 4'hF, 0, 0, 0, 1, 4'h0, 0, 0, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 1, 1, 32'h0));
    // Slave 3 read with a stray slave-1 response, then back-to-back request.
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h3000_0000, 0, 4'b1000, 0, 0, 0,
                      1, 4'b1000, 0, 1, 32'h0));
    tbl.push_back(idle(4'b0010, 1, 32'h1111_1111, 0, 1, 32'h0));
    tbl.push_back(idle(4'b1000, 3, 32'hCAFE_0003, 0, 1, 32'h0));
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h1000_0004, 0, 4'b0010, 0, 0, 0,
                      1, 4'b0010, 1, 0, 32'hCAFE_0003));
    tbl.push_back(idle(4'b0010, 1, 32'h0BAD_F00D, 0, 0, 32'hCAFE_0003));
    tbl.push_back(idle(4'h0, 0, 0, 1, 0, 32'h0BAD_F00D));
    // Reset mid-transaction; the late response is dropped.
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h2000_0000, 0, 4'b0100, 0, 0, 0,
                      1, 4'b0100, 0, 0, 32'h0BAD_F00D));
    tbl.push_back(row(0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0));
    tbl.push_back(idle(4'b0100, 2, 32'h5555_5555, 0, 0, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'h0));
`ifdef BUS_TIMEOUT_EN
    // Slave 1 never answers: error after TO cycles, late response ignored.
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h1000_0000, 0, 4'b0010, 0, 0, 0,
                      1, 4'b0010, 0, 0, 32'h0));
    for (int i = 0; i < int'(TO); i++) tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 1, 1, 32'h0));
    tbl.push_back(idle(4'b0010, 1, 32'h7777_7777, 0, 1, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 0, 1, 32'h0));
    // Response in the expiry cycle wins.
    tbl.push_back(row(1, 1, 0, 4'hF, 32'h1000_0000, 0, 4'b0010, 0, 0, 0,
                      1, 4'b0010, 0, 1, 32'h0));
    for (int i = 0; i < int'(TO) - 1; i++) tbl.push_back(idle(4'h0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(idle(4'b0010, 1, 32'h600D_DA7A, 0, 1, 32'h0));
    tbl.push_back(idle(4'h0, 0, 0, 1, 0, 32'h600D_DA7A));
    tbl.push_back(idle(4'h0, 0, 0, 0, 0, 32'h600D_DA7A));
`endif
    foreach (tbl[i]) step(tbl[i], 1, $sformatf("vec%0d", i));

    // Randomized traffic checked against the transaction-level model.
    v = idle(4'h0, 0, 0, 0, 0, 32'h0);
    v.rst = 0;
    step(v, 0, "rnd_rst");
    for (int c = 0; c < 3000; c++) begin
      v = row(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6), 1'($urandom),
              4'($urandom), {4'($urandom_range(0, 5)), 28'($urandom)}, $urandom,
              4'($urandom), 4'($urandom) & 4'($urandom), int'($urandom_range(0, 3)),
              $urandom, 0, 4'h0, 0, 0, 32'h0);
      step(v, 0, $sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_bus_mux.md
# soc_bus_mux

Parametrised data-bus interconnect between the RISC-V core's load/store port and N memory-mapped slaves (RAM, UART, GPIO, timer, interrupt controller). It replaces the fixed point-to-point core-to-RAM wiring in the SoC top. It decodes the upper address nibble to select a slave, forwards a single outstanding request with a req/gnt handshake, and returns a registered response. Unmapped and (optionally) timed-out accesses are answered with an error response so the core never hangs.

## Interface
Parameters:
- N_SLV, 4, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- TIMEOUT, 255, response timeout in cycles (only with BUS_TIMEOUT_EN); must be at least 1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_req_i  in  1  core request valid
- m_we_i  in  1  1 = write, 0 = read
- m_be_i  in  DATA_W/8  byte enables
- m_addr_i  in  ADDR_W  byte address
- m_wdata_i  in  DATA_W  write data
- m_gnt_o  out  1  request accepted this cycle
- m_rvalid_o  out  1  response valid (one cycle per accepted request)
- m_rdata_o  out  DATA_W  read data (0 for writes and errors)
- m_err_o  out  1  error qualifier for m_rvalid_o
- s_req_o  out  N_SLV  one-hot request to the selected slave
- s_we_o, s_be_o, s_addr_o, s_wdata_o  out  1 / DATA_W/8 / ADDR_W / DATA_W  broadcast copies of the master fields
- s_gnt_i  in  N_SLV  per-slave grant
- s_rvalid_i  in  N_SLV  per-slave response valid (reads and writes)
- s_rdata_i  in  N_SLV*DATA_W  packed read data; slave k occupies bits [k*DATA_W +: DATA_W]

## Operation
- Slave index: idx = m_addr_i[ADDR_W-1 -: 4]. idx >= N_SLV is unmapped.
- The FSM has three states: IDLE, WAIT_RSP and ERR_RSP.
- IDLE, mapped access:
  - s_req_o[idx] = m_req_i (combinational); all other bits are 0.
  - m_gnt_o = m_req_i & s_gnt_i[idx].
  - On grant: latch idx into sel_q, clear the timeout counter, go to WAIT_RSP.
- IDLE, unmapped access:
  - s_req_o stays 0 and m_gnt_o = m_req_i.
  - On grant: go to ERR_RSP.
- WAIT_RSP:
  - s_req_o = 0 and m_gnt_o = 0.
  - When s_rvalid_i[sel_q] = 1, register m_rdata_o = slice sel_q of s_rdata_i (0 if the access was a write), set m_err_o = 0, pulse m_rvalid_o, go to IDLE.
- ERR_RSP: pulse m_rvalid_o with m_err_o = 1 and m_rdata_o = 0, then go to IDLE.
- s_rvalid_i bits other than sel_q, and any s_rvalid_i seen outside WAIT_RSP, are ignored.
- One outstanding transaction at a time. m_req_i may be held with changing fields until granted; only fields present in the grant cycle are used.

## Timing
- Reset values: state IDLE, sel_q 0, counter 0; m_rvalid_o, m_err_o and m_rdata_o all 0. Combinational outputs are 0 when m_req_i = 0.
- Reset asserted mid-transaction returns to IDLE immediately with no response. A slave response that arrives later is dropped.
- Grant at edge T. The slave's s_rvalid_i is high no earlier than the cycle after T, at edge T+k with k ≥ 1. m_rvalid_o is high during the cycle after edge T+k.
- Minimum latency: grant cycle to m_rvalid_o cycle is 2 cycles.
- Unmapped access: m_rvalid_o with m_err_o = 1 is high during the second cycle after the grant cycle.
- m_rvalid_o is a single-cycle pulse. The cycle in which it is high is in IDLE, so a new request can be granted in that same cycle (back-to-back throughput of one access per 2 cycles at best).
- m_rdata_o and m_err_o hold their values until the next response.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A counter runs in WAIT_RSP. If s_rvalid_i[sel_q] is still low after TIMEOUT cycles in WAIT_RSP, the block issues an error response (m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0) and returns to IDLE.
  - A response arriving in the same cycle that the count expires takes priority as a normal response.
- BUS_TIMEOUT_EN undefined: no counter is built, TIMEOUT is unused, and WAIT_RSP waits indefinitely.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> all outputs 0. Release rst_n -> state IDLE, no m_rvalid_o.
- Read from slave 2: addr 0x2000_0010, s_gnt_i[2] = 1, s_rvalid_i[2] one cycle later with data 0xDEAD_BEEF -> s_req_o = 4'b0100 during the grant cycle, then m_rvalid_o = 1 and m_rdata_o = 0xDEAD_BEEF one cycle after s_rvalid_i[2].
- Write to slave 0 with m_be_i = 4'b0011, slave grant delayed 3 cycles -> m_gnt_o stays low for 3 cycles, s_be_o = 4'b0011, then response with m_err_o = 0 and m_rdata_o = 0.
- Unmapped access: addr 0x9000_0000 with N_SLV = 4 -> immediate m_gnt_o, s_req_o = 0, m_rvalid_o and m_err_o high 2 cycles later.
- Timeout with BUS_TIMEOUT_EN and TIMEOUT = 8: slave grants but never responds -> error response after 8 cycles in WAIT_RSP. A late s_rvalid_i then produces no m_rvalid_o.
- Back-to-back: new request presented in the m_rvalid_o cycle, plus a stray s_rvalid_i[1] while sel_q = 3 -> second request granted in that cycle, and the stray response is ignored.
